reg_scoreboard: RTL
===================

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have parameter SEL_W, default 3, meaning select width; entry count N = 2**SEL_W; legal range 1..6.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port iss_vld  input  1  issue request: mark entry iss_sel busy.
REQ-005 SHALL have port iss_sel  input  SEL_W  issue destination index.
REQ-006 SHALL have port iss_rdy  output  1  issue can be accepted this cycle (combinational).
REQ-007 SHALL have port wb_vld  input  1  writeback: clear entry wb_sel.
REQ-008 SHALL have port wb_sel  input  SEL_W  writeback index.
REQ-009 SHALL have ports rd_sel_a, rd_sel_b  input  SEL_W  lookup indices.
REQ-010 SHALL have ports rd_busy_a, rd_busy_b  output  1  busy bit of the looked-up entry (combinational from registered state).
REQ-011 SHALL have port busy_vec  output  N  registered busy bit per entry.
REQ-012 SHALL have port busy_cnt  output  SEL_W+1  registered count of set bits in busy_vec.
REQ-013 SHALL have port wb_err  output  1  sticky error flag, registered.

Function
REQ-014 SHALL decode iss_sel and wb_sel to N-bit one-hot masks; masks gated to zero when the respective valid is low.
REQ-015 SHALL drive iss_rdy = NOT busy_vec[iss_sel], independent of iss_vld and of same-cycle writeback.
REQ-016 SHALL accept an issue when iss_vld AND iss_rdy; accepted issue sets busy_vec[iss_sel] on the next edge.
REQ-017 SHALL, on iss_vld with iss_rdy low, leave state unchanged (WAW stall); requester holds iss_sel.
REQ-018 SHALL clear busy_vec[wb_sel] on the next edge when wb_vld and the entry is busy.
REQ-019 SHALL set wb_err on the next edge when wb_vld and busy_vec[wb_sel] is 0; wb_err stays set until reset.
REQ-020 SHALL, for issue and writeback to different entries in one cycle, apply both; busy_cnt unchanged.
REQ-021 SHALL, for same-entry issue and writeback in one cycle with entry busy, apply only the clear (iss_rdy low); entry 0 after the edge.
REQ-022 SHALL, for same-entry issue and writeback in one cycle with entry free, accept the issue, set wb_err; entry 1 after the edge.
REQ-023 SHALL update busy_cnt in the same edge as busy_vec: +1 accepted set only, -1 clear only, unchanged otherwise; busy_cnt always equals popcount(busy_vec).
REQ-024 SHALL never exceed N in busy_cnt; when all N entries busy, iss_rdy is 0 for every index.
REQ-025 SHALL provide rd_busy_a/b from registered busy_vec only; no bypass of same-cycle issue or writeback.

Reset
REQ-026 SHALL, while rst high, force busy_vec = 0, busy_cnt = 0, wb_err = 0 immediately, regardless of clk.
REQ-027 SHALL, with rst high, produce iss_rdy = 1 and rd_busy_a/b = 0; requests during reset are discarded.
REQ-028 SHALL resume normal operation on the first rising clk edge after rst deasserts.

Configuration
REQ-029 SHALL support macro SB_ZERO_HARDWIRE_EN.
REQ-030 SHALL, with SB_ZERO_HARDWIRE_EN defined, hold busy_vec[0] = 0 permanently, drive iss_rdy = 1 for iss_sel 0 without changing state, ignore writeback to entry 0 with no wb_err, and never count entry 0 in busy_cnt.
REQ-031 SHALL, without SB_ZERO_HARDWIRE_EN, treat entry 0 identically to every other entry.

Verification
REQ-032 SHALL cover: reset, issue sel 5, then rd_sel_a 5 -> busy_vec 8'h20, busy_cnt 1, rd_busy_a 1 one cycle after issue.
REQ-033 SHALL cover: issue sel 3, re-issue sel 3 next cycle -> iss_rdy 0, busy_vec stays 8'h08; wb sel 3 -> busy_vec 8'h00, iss_rdy 1.
REQ-034 SHALL cover: busy_vec 8'h04, same cycle issue sel 1 and wb sel 2 -> busy_vec 8'h02, busy_cnt 1, wb_err 0.
REQ-035 SHALL cover: wb sel 6 with busy_vec 0 -> wb_err 1 next cycle and stays 1 after later valid traffic until rst.
REQ-036 SHALL cover: issue all 8 entries -> busy_vec 8'hFF, busy_cnt 8, iss_rdy 0 for every iss_sel; assert rst mid-cycle -> all outputs reset without clock edge.
REQ-037 SHALL cover: with SB_ZERO_HARDWIRE_EN, issue sel 0 twice, wb sel 0 -> busy_vec 0, busy_cnt 0, wb_err 0, iss_rdy 1; without macro -> second issue stalls, busy_vec 8'h01.

Source files
------------

// File: rtl/reg_scoreboard.sv
// Register busy scoreboard: issue marks an entry busy, writeback clears it.
// Optional SB_ZERO_HARDWIRE_EN keeps entry 0 permanently free.
module reg_scoreboard #(
  parameter int SEL_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               iss_vld,
  input  logic [SEL_W-1:0]   iss_sel,
  output logic               iss_rdy,
  input  logic               wb_vld,
  input  logic [SEL_W-1:0]   wb_sel,
  input  logic [SEL_W-1:0]   rd_sel_a,
  input  logic [SEL_W-1:0]   rd_sel_b,
  output logic               rd_busy_a,
  output logic               rd_busy_b,
  output logic [2**SEL_W-1:0] busy_vec,
  output logic [SEL_W:0]     busy_cnt,
  output logic               wb_err
);

  localparam int N = 2**SEL_W;
  localparam logic [SEL_W:0] ONE = 1;

`ifdef SB_ZERO_HARDWIRE_EN
  localparam logic [N-1:0] LIVE = {{(N-1){1'b1}}, 1'b0};
`else
  localparam logic [N-1:0] LIVE = {N{1'b1}};
`endif

  logic [N-1:0] iss_mask;
  logic [N-1:0] wb_mask;
  logic [N-1:0] set_mask;
  logic [N-1:0] clr_mask;
  logic         inc;
  logic         dec;
  logic         err_hit;

  always_comb begin
    iss_mask          = '0;
    wb_mask           = '0;
    iss_mask[iss_sel] = iss_vld;
    wb_mask[wb_sel]   = wb_vld;
  end

  // Set and clear masks are disjoint: sets hit free entries, clears busy ones.
  assign set_mask = iss_mask & ~busy_vec & LIVE;
  assign clr_mask = wb_mask & busy_vec & LIVE;
  assign err_hit  = |(wb_mask & ~busy_vec & LIVE);
  assign inc      = |set_mask;
  assign dec      = |clr_mask;

  assign iss_rdy   = ~busy_vec[iss_sel];
  assign rd_busy_a = busy_vec[rd_sel_a];
  assign rd_busy_b = busy_vec[rd_sel_b];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_vec <= '0;
      busy_cnt <= '0;
      wb_err   <= 1'b0;
    end else begin
      busy_vec <= (busy_vec & ~clr_mask) | set_mask;
      if (inc && !dec)
        busy_cnt <= busy_cnt + ONE;
      else if (dec && !inc)
        busy_cnt <= busy_cnt - ONE;
      if (err_hit)
        wb_err <= 1'b1;
    end
  end

endmodule
